// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the fetch request unit.
//   word_t        : 32-bit machine word
//   fetch_state_t : FETCH / DATA / HALTED
//   pc_ctrl_t     : control-flow bits steering next-PC selection
// No ports (package).
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DATA   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic jumpreg;
      logic jump;
      logic branch_take;
   } pc_ctrl_t;

   localparam word_t WORD_STEP = 32'd4;

endpackage

// File: rtl/fetch_request_unit_if.sv
// fetch_request_unit_if -- groups the decode-side controls, memory handshakes
// and PC outputs of the fetch request unit.
//   slave  : the fetch unit (drives pc, pc_plus4, requests, halt_out, mem_err,
//            state_dbg; samples everything else)
//   master : the surrounding pipeline / memory model
// Handshake: a request output (imemREN, dmemREN, dmemWEN) stays asserted until
// the matching hit (ihit for instruction reads, dhit for data accesses) is
// seen on a rising clock edge; the transfer completes on that edge.
interface fetch_request_unit_if;
   import cpu_types_pkg::*;

   logic         ihit;
   logic         dhit;
   logic         branch_take;
   logic         jump;
   logic         jumpreg;
   logic [15:0]  immediate;
   logic [25:0]  j_addr;
   word_t        jregaddr;
   logic         halt;
   logic         dREN_in;
   logic         dWEN_in;
   word_t        pc;
   word_t        pc_plus4;
   logic         imemREN;
   logic         dmemREN;
   logic         dmemWEN;
   logic         halt_out;
   logic         mem_err;
   fetch_state_t state_dbg;

   modport slave (
      input  ihit, dhit, branch_take, jump, jumpreg, immediate, j_addr,
             jregaddr, halt, dREN_in, dWEN_in,
      output pc, pc_plus4, imemREN, dmemREN, dmemWEN, halt_out, mem_err,
             state_dbg
   );

   modport master (
      output ihit, dhit, branch_take, jump, jumpreg, immediate, j_addr,
             jregaddr, halt, dREN_in, dWEN_in,
      input  pc, pc_plus4, imemREN, dmemREN, dmemWEN, halt_out, mem_err,
             state_dbg
   );

endinterface

// File: rtl/npc_calc.sv
// npc_calc -- combinational next-PC selection.
//   pc, ctrl (jumpreg/jump/branch_take), immediate, j_addr, jregaddr : in
//   npc      : selected next PC (jumpreg > jump > branch > pc+4)
//   pc_plus4 : pc + 4 (wraps modulo 2^32)
module npc_calc
   import cpu_types_pkg::*;
(
   input  word_t       pc,
   input  pc_ctrl_t    ctrl,
   input  logic [15:0] immediate,
   input  logic [25:0] j_addr,
   input  word_t       jregaddr,
   output word_t       npc,
   output word_t       pc_plus4
);

   word_t br_off;

   assign pc_plus4 = pc + WORD_STEP;
   // Word offset: sign-extend then scale by 4.
   assign br_off   = {{14{immediate[15]}}, immediate, 2'b00};

   always_comb begin
      npc = pc_plus4;
      if (ctrl.jumpreg)
         npc = jregaddr;
      else if (ctrl.jump)
         npc = {pc_plus4[31:28], j_addr, 2'b00};
      else if (ctrl.branch_take)
         npc = pc_plus4 + br_off;
   end

endmodule

// File: rtl/fetch_request_unit.sv
// fetch_request_unit -- holds the PC, issues instruction reads, forwards
// decoded loads/stores as data requests and stops on HALT.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : fetch_request_unit_if.slave (controls, hits, pc/requests out)
// Parameters: PC_INIT (reset PC), TIMEOUT_CYCLES (data wait limit).
// Optional feature macro MEM_TIMEOUT_EN: bounds the DATA wait; on expiry it
// raises mem_err and halt_out and halts. Undefined: DATA waits forever and
// mem_err is tied to 0.
module fetch_request_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT        = 32'h0000_0000,
   parameter int    TIMEOUT_CYCLES = 255
) (
   input logic                  CLK,
   input logic                  nRST,
   fetch_request_unit_if.slave  bus
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        npc_q, npc_d;
   logic         dren_q, dren_d;
   logic         dwen_q, dwen_d;
   logic         halt_q, halt_d;
   word_t        npc;
   word_t        pc_plus4;
   pc_ctrl_t     ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`else
   // TIMEOUT_CYCLES only matters when the timeout is built in.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   assign ctrl = '{jumpreg: bus.jumpreg, jump: bus.jump,
                   branch_take: bus.branch_take};

   npc_calc u_npc_calc (
      .pc        (pc_q),
      .ctrl      (ctrl),
      .immediate (bus.immediate),
      .j_addr    (bus.j_addr),
      .jregaddr  (bus.jregaddr),
      .npc       (npc),
      .pc_plus4  (pc_plus4)
   );

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
         npc_q   <= '0;
         dren_q  <= 1'b0;
         dwen_q  <= 1'b0;
         halt_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         dren_q  <= dren_d;
         dwen_q  <= dwen_d;
         halt_q  <= halt_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      npc_d   = npc_q;
      dren_d  = dren_q;
      dwen_d  = dwen_q;
      halt_d  = halt_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         FETCH: begin
            if (bus.ihit) begin
               // HALT beats any decoded memory op.
               if (bus.halt) begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end else if (bus.dREN_in || bus.dWEN_in) begin
                  state_d = DATA;
                  dren_d  = bus.dREN_in;
                  dwen_d  = bus.dWEN_in;
                  npc_d   = npc;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  pc_d = npc;
               end
            end
         end
         DATA: begin
            // dhit wins over a timeout expiring on the same edge.
            if (bus.dhit) begin
               state_d = FETCH;
               pc_d    = npc_q;
               dren_d  = 1'b0;
               dwen_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // This edge closes the TIMEOUT_CYCLES-th waiting cycle.
               state_d = HALTED;
               dren_d  = 1'b0;
               dwen_d  = 1'b0;
               halt_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`endif
            end
         end
         HALTED: begin
         end
         default: state_d = FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      bus.pc        = pc_q;
      bus.pc_plus4  = pc_plus4;
      bus.imemREN   = (state_q == FETCH);
      bus.dmemREN   = dren_q;
      bus.dmemWEN   = dwen_q;
      bus.halt_out  = halt_q;
      bus.state_dbg = state_q;
`ifdef MEM_TIMEOUT_EN
      bus.mem_err   = err_q;
`else
      bus.mem_err   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_fetch_request_unit.sv
// tb_fetch_request_unit -- directed and randomized checks of
// fetch_request_unit against an architectural reference model.
module tb_fetch_request_unit;
   import cpu_types_pkg::*;

   localparam logic [31:0] PC_INIT = 32'h0000_0000;
   localparam int          TB_TO   = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   fetch_request_unit_if bus ();

   fetch_request_unit #(.PC_INIT(PC_INIT), .TIMEOUT_CYCLES(TB_TO)) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_target;
   logic        m_busy;
   logic        m_rd;
   logic        m_wr;
   logic        m_halted;
   logic        m_err;
   int          m_wait;

   function automatic logic [31:0] ref_next(input logic [31:0] cur);
      logic [31:0] seq;
      logic [31:0] jt;
      seq = cur + 32'd4;
      jt  = (seq & 32'hF000_0000) | (32'(bus.j_addr) * 32'd4);
      if (bus.jumpreg)          return bus.jregaddr;
      else if (bus.jump)        return jt;
      else if (bus.branch_take) return seq + 32'($signed(bus.immediate)) * 32'd4;
      else                      return seq;
   endfunction

   task automatic model_reset();
      m_pc = PC_INIT; m_target = '0; m_busy = 0; m_rd = 0; m_wr = 0;
      m_halted = 0; m_err = 0; m_wait = 0;
   endtask

   task automatic model_edge();
      logic [31:0] t;
      t = ref_next(m_pc);
      if (m_halted) begin
      end else if (m_busy) begin
         if (bus.dhit) begin
            m_busy = 0; m_rd = 0; m_wr = 0; m_pc = m_target;
         end else begin
            m_wait++;
`ifdef MEM_TIMEOUT_EN
            if (m_wait >= TB_TO) begin
               m_busy = 0; m_rd = 0; m_wr = 0; m_halted = 1; m_err = 1;
            end
`endif
         end
      end else if (bus.ihit) begin
         if (bus.halt) m_halted = 1;
         else if (bus.dREN_in || bus.dWEN_in) begin
            m_busy = 1; m_rd = bus.dREN_in; m_wr = bus.dWEN_in;
            m_target = t; m_wait = 0;
         end else m_pc = t;
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      fetch_state_t es;
      es = m_halted ? HALTED : (m_busy ? DATA : FETCH);
      check({tag, ":pc"},       bus.pc,        m_pc);
      check({tag, ":pc4"},      bus.pc_plus4,  m_pc + 32'd4);
      check({tag, ":imemREN"},  32'(bus.imemREN),  32'(!m_busy && !m_halted));
      check({tag, ":dmemREN"},  32'(bus.dmemREN),  32'(m_rd));
      check({tag, ":dmemWEN"},  32'(bus.dmemWEN),  32'(m_wr));
      check({tag, ":halt_out"}, 32'(bus.halt_out), 32'(m_halted));
      check({tag, ":mem_err"},  32'(bus.mem_err),  32'(m_err));
      check({tag, ":state"},    32'(bus.state_dbg), 32'(es));
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_in();
      bus.ihit = 0; bus.dhit = 0; bus.branch_take = 0; bus.jump = 0;
      bus.jumpreg = 0; bus.immediate = '0; bus.j_addr = '0;
      bus.jregaddr = '0; bus.halt = 0; bus.dREN_in = 0; bus.dWEN_in = 0;
   endtask

   // Inputs are already applied; advance one edge and compare.
   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      clear_in();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset_async");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic goto_pc(input logic [31:0] a);
      clear_in();
      bus.ihit = 1; bus.jumpreg = 1; bus.jregaddr = a;
      step("goto");
      clear_in();
   endtask

   task automatic drive_random();
      clear_in();
      bus.ihit        = ($urandom_range(0, 3) != 0);
      bus.dhit        = ($urandom_range(0, 2) == 0);
      bus.branch_take = ($urandom_range(0, 3) == 0);
      bus.jump        = ($urandom_range(0, 7) == 0);
      bus.jumpreg     = ($urandom_range(0, 7) == 0);
      bus.immediate   = 16'($urandom);
      bus.j_addr      = 26'($urandom);
      bus.jregaddr    = $urandom & 32'hFFFF_FFFC;
      bus.halt        = ($urandom_range(0, 39) == 0);
      bus.dREN_in     = ($urandom_range(0, 4) == 0);
      bus.dWEN_in     = ($urandom_range(0, 4) == 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      clear_in();
      model_reset();
      do_reset();
      check("first_imemREN", 32'(bus.imemREN), 32'd1);

      // Sequential fetch: 0,4,8,12
      exp_q = '{32'd4, 32'd8, 32'd12};
      bus.ihit = 1;
      for (int i = 0; i < 3; i++) begin
         step("seq");
         check("seq_pc", bus.pc, exp_q.pop_front());
      end

      // Backward branch from 0x40
      goto_pc(32'h40);
      bus.ihit = 1; bus.branch_take = 1; bus.immediate = 16'hFFFE;
      step("branch");
      check("branch_pc", bus.pc, 32'h3C);

      // Priority: jumpreg over jump over branch
      clear_in();
      bus.ihit = 1; bus.jump = 1; bus.jumpreg = 1; bus.branch_take = 1;
      bus.jregaddr = 32'h100; bus.j_addr = 26'h3;
      step("jr_prio");
      check("jr_pc", bus.pc, 32'h100);
      clear_in();
      bus.ihit = 1; bus.jump = 1; bus.branch_take = 1; bus.j_addr = 26'h20;
      step("j_prio");
      check("j_pc", bus.pc, 32'h80);

      // Wrap-around
      goto_pc(32'hFFFF_FFFC);
      check("wrap_pc4", bus.pc_plus4, 32'h0);
      bus.ihit = 1;
      step("wrap");
      check("wrap_pc", bus.pc, 32'h0);

      // Load: 3 DATA cycles then dhit
      goto_pc(32'h10);
      bus.ihit = 1; bus.dREN_in = 1;
      step("ld_issue");
      clear_in();
      bus.ihit = 1;  // ignored in DATA
      for (int i = 0; i < 3; i++) begin
         check("ld_dren", 32'(bus.dmemREN), 32'd1);
         check("ld_imem", 32'(bus.imemREN), 32'd0);
         check("ld_pc",   bus.pc, 32'h10);
         if (i < 2) step("ld_wait");
      end
      bus.ihit = 0; bus.dhit = 1;
      step("ld_done");
      check("ld_pc_after", bus.pc, 32'h14);

      // Both request bits; dhit ignored in FETCH
      clear_in();
      bus.dhit = 1;
      step("dhit_fetch");
      bus.ihit = 1; bus.dhit = 0; bus.dREN_in = 1; bus.dWEN_in = 1;
      step("ldst_issue");
      clear_in(); bus.dhit = 1;
      step("ldst_done");

      // Reset during DATA
      bus.dhit = 0; bus.ihit = 1; bus.dWEN_in = 1;
      step("st_issue");
      clear_in();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_dwen", 32'(bus.dmemWEN), 32'd0);
      check_all("rst_mid_data");
      @(negedge clk);
      rst_n = 1'b1;
      bus.dhit = 1;
      step("dhit_after_rst");

      // Halt: later pulses ignored
      clear_in();
      bus.ihit = 1; bus.halt = 1; bus.dREN_in = 1;
      step("halt");
      check("halt_out", 32'(bus.halt_out), 32'd1);
      for (int i = 0; i < 4; i++) begin
         clear_in();
         bus.ihit = i[0]; bus.dhit = ~i[0];
         step("halted_hold");
      end

`ifdef MEM_TIMEOUT_EN
      // Store with no dhit times out
      do_reset();
      bus.ihit = 1; bus.dWEN_in = 1;
      step("to_issue");
      clear_in();
      for (int i = 0; i < TB_TO; i++) step("to_wait");
      check("to_err",  32'(bus.mem_err), 32'd1);
      check("to_halt", 32'(bus.halt_out), 32'd1);
      check("to_dwen", 32'(bus.dmemWEN), 32'd0);
      // dhit on the final cycle wins
      do_reset();
      bus.ihit = 1; bus.dREN_in = 1;
      step("to2_issue");
      clear_in();
      for (int i = 0; i < TB_TO - 1; i++) step("to2_wait");
      bus.dhit = 1;
      step("to2_dhit");
      check("to2_err", 32'(bus.mem_err), 32'd0);
`else
      // DATA waits well past the nominal limit
      do_reset();
      bus.ihit = 1; bus.dWEN_in = 1;
      step("nto_issue");
      clear_in();
      for (int i = 0; i < TB_TO + 6; i++) step("nto_wait");
      check("nto_dwen", 32'(bus.dmemWEN), 32'd1);
      bus.dhit = 1;
      step("nto_done");
`endif

      // Randomized phase, periodic reset to leave HALTED
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 49) do_reset();
         drive_random();
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

endmodule
